pe_result_drain: RTL and testbench
==================================

# pe_result_drain

Result collector for the 8x8 PE cluster. It watches the per-PE done vector. When the last PE finishes, it snapshots the full accumulator bus in one cycle. It then streams the 64 accumulators out one per beat over a valid/ready handshake, in row-major order. It sits downstream of the cluster and replaces bench-side dumping of the raw results bus.

## Interface
Parameters:
- ROWS, 8, PE rows in the cluster
- COLS, 8, PE columns in the cluster
- ACC_W, 36, accumulator width per PE (results bus = ROWS*COLS*ACC_W = 2304)
- OUT_W, 16, streamed word width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  global enable; 0 stalls every state change and transfer
- results  in  ROWS*COLS*ACC_W  cluster accumulators; PE k = r*COLS+c at [k*ACC_W +: ACC_W], signed
- output_dones  in  ROWS*COLS  per-PE done flags from the cluster
- out_data  out  OUT_W  current word
- out_idx  out  6  PE index k of the current word
- out_valid  out  1  word available
- out_ready  in  1  sink accepts the word
- out_last  out  1  high with out_idx==63
- busy  out  1  high in STREAM
- drain_done  out  1  high in DONE

## Operation
- Reset values: out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0, drain_done=0, snapshot buffer=0, state=IDLE, done_q=0.
- A transfer occurs when en && out_valid && out_ready.
- done_q is the registered copy of output_dones[63]. A trigger is output_dones[63] && !done_q, sampled only when en=1.
- IDLE: on trigger, latch all of results into the buffer, set out_idx=0, out_valid=1, and go to STREAM.
- STREAM: out_data = convert(buffer[out_idx]).
  - On a transfer with idx<63: idx+1 and out_valid stays 1.
  - On a transfer with idx==63: out_valid=0 and go to DONE.
- DONE: drain_done=1. When output_dones[63]==0 (cluster reset for the next tile), go to IDLE. The buffer is retained.
- Triggers in STREAM or DONE are ignored; the buffer is never overwritten mid-drain.
- Handshake: while out_valid=1 and no transfer, out_data, out_idx and out_last hold stable. out_valid never drops without a transfer, except on rst_n.
- en=0: no state, index, capture or done_q update. Outputs hold.
- rst_n low mid-drain: abort immediately to reset values. Words not yet sent are lost.
- Conversion without the macro: out_data = low OUT_W bits of the accumulator (two's-complement wrap).

## Timing
- Trigger sampled at edge N. Buffer loaded and out_valid=1 with idx 0 visible after edge N.
- With out_ready held high, the stream runs 64 beats in 64 consecutive cycles.
- busy drops and drain_done rises the cycle after the idx-63 transfer.
- Trigger to drain_done with no backpressure: 65 cycles.
- Each ready-low cycle adds exactly one cycle; there are no bubbles otherwise.
- out_data is combinational from the buffer and the registered idx. No extra pipeline stage.

## Configuration
- DRAIN_SAT_EN defined: out_data = signed saturation of the ACC_W value to OUT_W.
  - Values above 2^(OUT_W-1)-1 clamp to 0x7FFF.
  - Values below -2^(OUT_W-1) clamp to 0x8000.
- DRAIN_SAT_EN undefined: plain truncation to the low OUT_W bits. No saturation logic is built.

## Structure
- Shared package: ACC_W, NUM_PE = ROWS*COLS, the state enum {IDLE, STREAM, DONE}, and a PE index type of 6 bits.
- One sub-module, drain_sat: combinational ACC_W to OUT_W converter. It contains the DRAIN_SAT_EN ifdef; its parameters are ACC_W and OUT_W.

## Test plan
- Reset and idle: rst_n=0 for 2 cycles, then output_dones=0 for 10 cycles -> all outputs 0, state IDLE.
- Full drain: load PE k with k+1 and raise output_dones[63] with out_ready=1.
  - Expect 64 beats carrying 1..64 with idx 0..63 and out_last only on idx 63.
  - Expect drain_done 65 cycles after the trigger.
- Backpressure: out_ready toggled 1,0,1,0 during the drain -> every word delivered exactly once, in order, stable during ready-low cycles, and the total length grows by the number of stall cycles.
- Saturation (DRAIN_SAT_EN): PE0=36'h0_0001_2345 gives 0x7FFF, PE1=-70000 gives 0x8000, PE2=-5 gives 0xFFFB. Without the macro, PE0 gives 0x2345.
- Abort and retrigger:
  - Assert rst_n=0 at idx 20 -> out_valid=0 the next cycle.
  - After a new trigger, streaming restarts at idx 0.
  - A second output_dones[63] edge during STREAM does not change the remaining words.
- en stall: en=0 for 5 cycles mid-stream with out_ready=1 -> out_idx is frozen, no transfer is counted, and the stream resumes at the same idx.

Source files
------------

// File: rtl/pe_result_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_result_drain_pkg
//  Description : Shared constants and types for the PE result drain: cluster
//                geometry, accumulator width, drain state encoding and the
//                PE index type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_result_drain_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int NUM_PE = ROWS * COLS;
    localparam int ACC_W  = 36;
    localparam int OUT_W  = 16;
    localparam int IDX_W  = 6;

    // Index of a PE within the cluster, row-major (k = r*COLS + c)
    typedef logic [IDX_W-1:0] pe_idx_t;

    // Drain sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_result_drain_if
//  Description : Valid/ready stream carrying one converted accumulator word
//                and its PE index per beat. master = drain, slave = sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_result_drain_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0]              out_data;
    pe_result_drain_pkg::pe_idx_t  out_idx;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/pe_result_drain_drain_sat.sv
`default_nettype none
// ============================================================================
//  Module      : drain_sat
//  Description : Combinational ACC_W -> OUT_W accumulator converter.
//                DRAIN_SAT_EN defined  : signed saturation to OUT_W.
//                DRAIN_SAT_EN undefined: two's-complement truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module drain_sat #(
    parameter int ACC_W = 36,
    parameter int OUT_W = 16
) (
    input  wire logic [ACC_W-1:0] i_acc,
    output logic      [OUT_W-1:0] o_data
);

`ifdef DRAIN_SAT_EN
    // The value fits when every bit from OUT_W-1 upward equals the sign bit
    logic [ACC_W-OUT_W:0] w_top;
    assign w_top = i_acc[ACC_W-1:OUT_W-1];

    // Clamp to the most positive / most negative OUT_W value on overflow
    always_comb begin
        o_data = i_acc[OUT_W-1:0];
        if (w_top != {(ACC_W-OUT_W+1){i_acc[ACC_W-1]}}) begin
            o_data = i_acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    // Upper accumulator bits are intentionally discarded by the wrap
    logic w_unused_hi;
    assign w_unused_hi = ^i_acc[ACC_W-1:OUT_W];
    assign o_data      = i_acc[OUT_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/pe_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pe_result_drain
//  Description : Snapshots the PE cluster accumulator bus when the last PE
//                finishes, then streams the accumulators out one per beat in
//                row-major order over a valid/ready interface.
//                Optional macro DRAIN_SAT_EN selects saturating conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_result_drain #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ACC_W = 36,
    parameter int OUT_W = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       en,
    input  wire logic [ROWS*COLS*ACC_W-1:0] results,
    input  wire logic [ROWS*COLS-1:0]       output_dones,
    pe_result_drain_if.master               out_if,
    output logic                            busy,
    output logic                            drain_done
);
    import pe_result_drain_pkg::*;

    localparam int      c_last    = ROWS * COLS - 1;
    localparam pe_idx_t c_idx_end = pe_idx_t'(c_last);
    localparam pe_idx_t c_idx_pre = pe_idx_t'(c_last - 1);

    drain_state_t                 state_q, state_d;
    logic [ROWS*COLS*ACC_W-1:0]   buf_q,   buf_d;
    pe_idx_t                      idx_q,   idx_d;
    logic                         valid_q, valid_d;
    logic                         last_q,  last_d;
    logic                         busy_q,  busy_d;
    logic                         ddone_q, ddone_d;
    logic                         done_q,  done_d;

    logic                         w_tail;
    logic                         w_xfer;
    logic                         w_trig;
    logic [ACC_W-1:0]             w_acc;
    logic [OUT_W-1:0]             w_word;

    assign w_tail = output_dones[c_last];
    assign w_xfer = en && valid_q && out_if.out_ready;
    assign w_trig = en && w_tail && !done_q;
    assign w_acc  = buf_q[int'(idx_q)*ACC_W +: ACC_W];

    drain_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_drain_sat (
        .i_acc  (w_acc),
        .o_data (w_word)
    );

    // Next-state logic: capture on trigger, step index per transfer, release on done low
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ddone_d = ddone_q;
        done_d  = done_q;

        if (en) begin
            done_d = w_tail;
        end

        case (state_q)
            IDLE: begin
                if (w_trig) begin
                    buf_d   = results;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Later done edges are ignored here so the snapshot stays intact
                if (w_xfer) begin
                    if (idx_q == c_idx_end) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        ddone_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        last_d = (idx_q == c_idx_pre);
                    end
                end
            end
            DONE: begin
                // Cluster clearing its done flag marks the start of the next tile
                if (en && !w_tail) begin
                    ddone_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ddone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ddone_q <= ddone_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_data  = w_word;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign drain_done       = ddone_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_result_drain
//  Description : Directed self-checking bench for pe_result_drain.
//                Honours DRAIN_SAT_EN for the conversion expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_result_drain;

    localparam int c_acc_w = 36;
    localparam int c_npe   = 64;

    logic                     clk;
    logic                     rst_n;
    logic                     en;
    logic [c_npe*c_acc_w-1:0] results;
    logic [c_npe-1:0]         dones;
    logic                     busy;
    logic                     drain_done;

    logic [15:0]              exp_word [c_npe];

    int n_tests;
    int n_fail;
    int cyc;
    int stl;

    pe_result_drain_if #(.OUT_W(16)) bus ();

    pe_result_drain #(
        .ROWS  (8),
        .COLS  (8),
        .ACC_W (c_acc_w),
        .OUT_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .results      (results),
        .output_dones (dones),
        .out_if       (bus),
        .busy         (busy),
        .drain_done   (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Trigger a drain and follow it beat by beat against exp_word.
    // alt_ready toggles ready 1,0,1,0; stall_k holds en low 5 cycles at that
    // index; abort_k pulls rst_n at that index; glitch_k re-pulses the done
    // flag and scrambles results at that index.
    task automatic run_drain(input bit alt_ready, input int stall_k, input int abort_k,
                             input int glitch_k, output int cycles, output int stalls);
        int k;
        int en_hold;
        int gphase;
        bit stalled;
        bit aborted;
        k = 0; cycles = 0; stalls = 0; en_hold = 0; gphase = 0;
        stalled = 0; aborted = 0;
        en = 1'b1;
        bus.out_ready = 1'b1;
        dones = '1;
        while (cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (aborted) begin
                check_eq("abort_valid", bus.out_valid, 0);
                check_eq("abort_idx", bus.out_idx, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_last", bus.out_last, 0);
                rst_n = 1'b1;
                break;
            end
            if (drain_done) break;
            check_eq("valid", bus.out_valid, 1);
            check_eq("idx", bus.out_idx, k);
            check_eq("data", bus.out_data, exp_word[k]);
            check_eq("last", bus.out_last, (k == 63));
            check_eq("busy", busy, 1);
            if (k == abort_k) begin
                rst_n = 1'b0;
                dones = '0;
                aborted = 1;
                continue;
            end
            if (gphase == 1) begin
                dones[63] = 1'b1;
                gphase = 2;
            end else if (k == glitch_k && gphase == 0) begin
                dones[63] = 1'b0;
                results = ~results;
                gphase = 1;
            end
            if (en_hold > 0) begin
                en_hold--;
                if (en_hold == 0) en = 1'b1;
            end else if (k == stall_k && !stalled) begin
                en = 1'b0;
                en_hold = 5;
                stalled = 1;
            end
            bus.out_ready = alt_ready ? cycles[0] : 1'b1;
            if (en && bus.out_ready) k++;
            else stalls++;
        end
        if (!aborted) begin
            check_eq("beats", k, 64);
            check_eq("drain_len", cycles, 65 + stalls);
            check_eq("end_done", drain_done, 1);
            check_eq("end_valid", bus.out_valid, 0);
            check_eq("end_busy", busy, 0);
        end
    endtask

    // Drop the done flag so the drain returns to idle
    task automatic release_done();
        dones = '0;
        @(negedge clk);
        check_eq("release_done", drain_done, 0);
        check_eq("release_busy", busy, 0);
        @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < c_npe; k++) begin
            results[k*c_acc_w +: c_acc_w] = 36'(k + 1);
            exp_word[k] = 16'(k + 1);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; en = 1'b1; dones = '0; results = '0;
        bus.out_ready = 1'b0;

        // Reset and idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_idx", bus.out_idx, 0);
        check_eq("rst_data", bus.out_data, 0);
        check_eq("rst_last", bus.out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drain_done", drain_done, 0);

        // Full drain without backpressure
        load_ramp();
        run_drain(0, -1, -1, -1, cyc, stl);
        check_eq("full_len", cyc, 65);
        release_done();

        // Ready toggling 1,0,1,0
        run_drain(1, -1, -1, -1, cyc, stl);
        check_eq("bp_len", cyc, 128);
        release_done();

        // Conversion of out-of-range and negative values
        load_ramp();
        results[0*c_acc_w +: c_acc_w] = 36'h0_0001_2345;
        results[1*c_acc_w +: c_acc_w] = 36'(-70000);
        results[2*c_acc_w +: c_acc_w] = 36'(-5);
`ifdef DRAIN_SAT_EN
        exp_word[0] = 16'h7FFF;
        exp_word[1] = 16'h8000;
`else
        exp_word[0] = 16'h2345;
        exp_word[1] = 16'hEE90;
`endif
        exp_word[2] = 16'hFFFB;
        run_drain(0, -1, -1, -1, cyc, stl);
        release_done();

        // Enable stall mid-stream
        load_ramp();
        run_drain(0, 30, -1, -1, cyc, stl);
        check_eq("en_stall_len", cyc, 70);
        release_done();

        // Abort at idx 20, then retrigger with a spurious done edge mid-stream
        run_drain(0, -1, 20, -1, cyc, stl);
        @(negedge clk);
        check_eq("post_abort_idle", bus.out_valid, 0);
        run_drain(0, -1, -1, 10, cyc, stl);
        check_eq("retrig_len", cyc, 65);
        release_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
